// File: rtl/sram_async_seq_if.sv
// Request/response and SRAM-adapter pin bundle for the async-SRAM sequencer.
// master = client/adapter side, slave = sequencer side.
interface sram_async_seq_if #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_we_n;
  logic          mem_oe_n;
  logic [1:0]    mem_be_n;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, mem_dout,
    input  req_ready, rdata, rvalid, done,
           mem_addr, mem_din, mem_we_n, mem_oe_n, mem_be_n
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, mem_dout,
    output req_ready, rdata, rvalid, done,
           mem_addr, mem_din, mem_we_n, mem_oe_n, mem_be_n
  );
endinterface

// File: rtl/sram_async_seq.sv
// Clocked sequencer driving an async-SRAM pin adapter: one request at a time,
// programmable access width, registered pin outputs and registered read data.
module sram_async_seq #(
  parameter int unsigned AW      = 17,
  parameter int unsigned DW      = 16,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  sram_async_seq_if.slave bus
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

  // Reject illegal builds at elaboration.
  if (DW != 16) begin : g_bad_dw
    $error("sram_async_seq: DW must be 16");
  end
  if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("sram_async_seq: RD_WAIT must be in 1..15");
  end
  if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
    $error("sram_async_seq: WR_WAIT must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    RD_ACC  = 3'd2,
    RD_REC  = 3'd3,
    WR_ACC  = 3'd4,
    WR_HOLD = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          ready_q, ready_d;
  logic          we_n_q, we_n_d;
  logic          oe_n_q, oe_n_d;
  logic [1:0]    be_n_q, be_n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          done_q, done_d;

  // Next state plus next values of every registered output.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    be_n_d   = be_n_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    rvalid_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = SETUP;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          be_n_d  = ~bus.req_be;
          if (bus.req_we) din_d = bus.req_wdata;
        end
      end
      SETUP: begin
        if (we_q) begin
          state_d = WR_ACC;
          cnt_d   = WR_LOAD;
        end else begin
          state_d = RD_ACC;
          cnt_d   = RD_LOAD;
        end
      end
      RD_ACC: begin
        if (cnt_q == '0) begin
          state_d = RD_REC;
          rdata_d = bus.mem_dout;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_REC: state_d = IDLE;
      WR_ACC: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      WR_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin-level outputs follow the state being entered so they are registered.
    if (state_d == IDLE) be_n_d = 2'b11;
    ready_d  = (state_d == IDLE);
    we_n_d   = (state_d != WR_ACC);
    oe_n_d   = (state_d != RD_ACC);
    rvalid_d = (state_d == RD_REC);
    done_d   = (state_d == RD_REC) || (state_d == WR_HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      be_n_q   <= 2'b11;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      be_n_q   <= be_n_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_we_n  = we_n_q;
  assign bus.mem_oe_n  = oe_n_q;
  assign bus.mem_be_n  = be_n_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.done      = done_q;

endmodule
